// File: rtl/fp_mult_pipe_if.sv
// rtl/fp_mult_pipe_if.sv - operand/result handshake bundle for fp_mult_pipe
interface fp_mult_pipe_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         rnd_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] x;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, rnd_mode, out_ready,
      input  in_ready, out_valid, x, flags
   );

   modport slave (
      input  in_valid, a, b, rnd_mode, out_ready,
      output in_ready, out_valid, x, flags
   );
endinterface

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - 3-stage parametrised floating-point multiplier
// S1 unpack/classify/exponent add, S2 significand multiply, S3 normalise/round/pack.
module fp_mult_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic          clk,
   input  logic          rst,
   fp_mult_pipe_if.slave bus
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int EW   = EXP_W + 2;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int BIAS = 2 ** (EXP_W - 1) - 1;

   localparam logic [EXP_W-1:0]        EXP_ONES = '1;
   localparam logic [EXP_W-1:0]        EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
   localparam logic signed [EW-1:0]    BIAS_S   = EW'(BIAS);
   localparam logic signed [EW-1:0]    EMAX     = EW'(2 ** EXP_W - 1);
   localparam logic signed [EW-1:0]    E_ONE    = EW'(1);
   localparam logic signed [EW-1:0]    E_ZERO   = '0;
   localparam logic [W-1:0]            QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   logic v1, v2, v3;
   logic adv;

   assign adv           = !v3 || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = v3;

   // ---------------- S1: unpack / classify / exponent add ----------------
   logic             sa, sb, sgn;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] ma, mb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic             spec;
   logic [W-1:0]     spec_x;
   logic [3:0]       spec_f;
   logic signed [EW-1:0] e_sum;

   assign {sa, ea, ma} = bus.a;
   assign {sb, eb, mb} = bus.b;
   assign sgn    = sa ^ sb;
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == EXP_ONES) && (ma == '0);
   assign b_inf  = (eb == EXP_ONES) && (mb == '0);
   assign a_nan  = (ea == EXP_ONES) && (ma != '0);
   assign b_nan  = (eb == EXP_ONES) && (mb != '0);
   assign e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

   always_comb begin
      spec   = 1'b1;
      spec_x = '0;
      spec_f = 4'b0000;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         spec_x = QNAN;
         spec_f = {(a_inf && b_zero) || (a_zero && b_inf), 3'b000};
      end else if (a_inf || b_inf) begin
         spec_x = {sgn, EXP_ONES, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
         spec_x = {sgn, {(W-1){1'b0}}};
      end else begin
         spec = 1'b0;
      end
   end

   logic                 s1_sign, s1_spec, s1_rtz;
   logic [W-1:0]         s1_spec_x;
   logic [3:0]           s1_spec_f;
   logic signed [EW-1:0] s1_e;
   logic [MAN_W:0]       s1_ma, s1_mb;

   // ---------------- S2: significand multiply ----------------
   logic                 s2_sign, s2_spec, s2_rtz;
   logic [W-1:0]         s2_spec_x;
   logic [3:0]           s2_spec_f;
   logic signed [EW-1:0] s2_e;
   logic [PW-1:0]        s2_p;

   // ---------------- S3: normalise / round / pack ----------------
   logic                 p_hi;
   logic [MAN_W-1:0]     frac, frac_r;
   logic                 g, st, inc, carry, inexact;
   logic signed [EW-1:0] e_n, e_r;
   logic [W-1:0]         rx;
   logic [3:0]           rf;

   // Product is in [1,4); the top bit decides which window holds the fraction.
   assign p_hi    = s2_p[PW-1];
   assign frac    = p_hi ? s2_p[PW-2 -: MAN_W] : s2_p[PW-3 -: MAN_W];
   assign g       = p_hi ? s2_p[MAN_W] : s2_p[MAN_W-1];
   assign st      = p_hi ? |s2_p[MAN_W-1:0] : |s2_p[MAN_W-2:0];
   assign e_n     = p_hi ? s2_e + E_ONE : s2_e;
   assign inc     = !s2_rtz && g && (st || frac[0]);
   assign {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
   assign e_r     = carry ? e_n + E_ONE : e_n;
   assign inexact = g || st;

   always_comb begin
      rx = '0;
      rf = 4'b0000;
      if (s2_spec) begin
         rx = s2_spec_x;
         rf = s2_spec_f;
      end else if (e_r >= EMAX) begin
         rf = 4'b0101;
         rx = s2_rtz ? {s2_sign, EXP_MAXF, {MAN_W{1'b1}}}
                     : {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      end else if (e_r <= E_ZERO) begin
         rf = 4'b0011;
         rx = {s2_sign, {(W-1){1'b0}}};
      end else begin
         rf = {3'b000, inexact};
         rx = {s2_sign, e_r[EXP_W-1:0], frac_r};
      end
   end

   logic [W-1:0] x_q;
   logic [3:0]   flags_q;

   assign bus.x     = x_q;
   assign bus.flags = flags_q;

   // A single advance enable moves every stage; bubbles travel as v*=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         s1_sign   <= 1'b0;
         s1_spec   <= 1'b0;
         s1_rtz    <= 1'b0;
         s1_spec_x <= '0;
         s1_spec_f <= '0;
         s1_e      <= '0;
         s1_ma     <= '0;
         s1_mb     <= '0;
         s2_sign   <= 1'b0;
         s2_spec   <= 1'b0;
         s2_rtz    <= 1'b0;
         s2_spec_x <= '0;
         s2_spec_f <= '0;
         s2_e      <= '0;
         s2_p      <= '0;
         x_q       <= '0;
         flags_q   <= '0;
      end else if (adv) begin
         v1        <= bus.in_valid;
         v2        <= v1;
         v3        <= v2;
         s1_sign   <= sgn;
         s1_spec   <= spec;
         s1_rtz    <= bus.rnd_mode;
         s1_spec_x <= spec_x;
         s1_spec_f <= spec_f;
         s1_e      <= e_sum;
         s1_ma     <= {1'b1, ma};
         s1_mb     <= {1'b1, mb};
         s2_sign   <= s1_sign;
         s2_spec   <= s1_spec;
         s2_rtz    <= s1_rtz;
         s2_spec_x <= s1_spec_x;
         s2_spec_f <= s1_spec_f;
         s2_e      <= s1_e;
         s2_p      <= {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};
         if (v2) begin
            x_q     <= rx;
            flags_q <= rf;
         end
      end
   end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - directed, backpressure, reset and random checks for fp_mult_pipe
module tb_fp_mult_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) bus ();

   fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        rm;
      logic [15:0] x;
      logic [3:0]  f;
   } vec_t;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: {flags, x} for fp16 built from integer remainder-vs-half rounding.
   function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic rm);
      int ea, eb, ma, mb, p, e, keep, rem, half;
      logic s, an, bn, ai, bi, az, bz, inx;
      logic [15:0] r;
      ea = int'(a[14:10]); eb = int'(b[14:10]);
      ma = int'(a[9:0]);   mb = int'(b[9:0]);
      s  = a[15] ^ b[15];
      an = (ea == 31) && (ma != 0); bn = (eb == 31) && (mb != 0);
      ai = (ea == 31) && (ma == 0); bi = (eb == 31) && (mb == 0);
      az = (ea == 0);               bz = (eb == 0);
      if (an || bn || (ai && bz) || (az && bi))
         return {((ai && bz) || (az && bi)) ? 4'b1000 : 4'b0000, 16'h7E00};
      if (ai || bi) return {4'b0000, s ? 16'hFC00 : 16'h7C00};
      if (az || bz) return {4'b0000, s ? 16'h8000 : 16'h0000};
      p = (1024 + ma) * (1024 + mb);
      e = ea + eb - 15;
      if (p >= (1 << 21)) begin
         keep = p >> 11; rem = p % 2048; half = 1024; e = e + 1;
      end else begin
         keep = p >> 10; rem = p % 1024; half = 512;
      end
      inx = (rem != 0);
      if (!rm && ((rem > half) || (rem == half && (keep % 2) == 1))) keep = keep + 1;
      if (keep == 2048) begin
         keep = 1024; e = e + 1;
      end
      if (e >= 31) return {4'b0101, rm ? {s, 15'h7BFF} : {s, 15'h7C00}};
      if (e <= 0)  return {4'b0011, s, 15'h0000};
      r = {s, e[4:0], keep[9:0]};
      return {3'b000, inx, r};
   endfunction

   function automatic logic [15:0] gen_op();
      if ($urandom_range(0, 3) != 0)
         return {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom_range(0, 1023))};
      return 16'($urandom);
   endfunction

   task automatic apply_vec(input vec_t v, input string name);
      int n;
      @(negedge clk);
      bus.a = v.a; bus.b = v.b; bus.rnd_mode = v.rm;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk);
      n = 1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (!bus.out_valid && n < 10) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check(n == 3, {name, "_latency"}, 32'(n), 32'd3);
      check(bus.x == v.x, {name, "_x"}, 32'(bus.x), 32'(v.x));
      check(bus.flags == v.f, {name, "_flags"}, 32'(bus.flags), 32'(v.f));
   endtask

   task automatic run_stream(input int n_ops, input bit scripted);
      logic [19:0] exp_q[$];
      logic [19:0] ev;
      logic [15:0] na, nb, hold_x;
      logic [3:0]  hold_f;
      logic        nrm;
      bit          have, stalled;
      int          sent, got, cyc, low_seen, extra;
      have = 0; stalled = 0; sent = 0; got = 0; cyc = 0; low_seen = 0; extra = 0;
      na = '0; nb = '0; nrm = 1'b0; hold_x = '0; hold_f = '0;
      while (got < n_ops && cyc < n_ops * 8 + 50) begin
         @(negedge clk);
         if (stalled)
            check(bus.out_valid && bus.x == hold_x && bus.flags == hold_f, "stall_hold",
                  {11'd0, bus.out_valid, bus.flags, bus.x}, {12'd1, hold_f, hold_x});
         if (!have && sent < n_ops) begin
            na = gen_op(); nb = gen_op(); nrm = 1'($urandom_range(0, 1)); have = 1;
         end
         bus.a = na; bus.b = nb; bus.rnd_mode = nrm;
         bus.in_valid  = have && (scripted || $urandom_range(0, 3) != 0);
         bus.out_ready = scripted ? !(cyc >= 4 && cyc < 9) : ($urandom_range(0, 3) != 0);
         #1;
         if (scripted) begin
            check(bus.in_ready == (!bus.out_valid || bus.out_ready), "in_ready",
                  32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (!bus.in_ready) low_seen++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_result", {12'd0, bus.flags, bus.x}, 32'd0);
            end else begin
               ev = exp_q.pop_front();
               check({bus.flags, bus.x} == ev, "stream_result", {12'd0, bus.flags, bus.x}, {12'd0, ev});
            end
            got++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         hold_x = bus.x; hold_f = bus.flags;
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_mul(na, nb, nrm));
            sent++;
            have = 0;
         end
         cyc++;
      end
      check(got == n_ops, "stream_count", 32'(got), 32'(n_ops));
      if (scripted) check(low_seen > 0, "in_ready_dropped", 32'(low_seen), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid) extra++;
      end
      check(extra == 0 && exp_q.size() == 0, "stream_no_dup", 32'(extra + exp_q.size()), 32'd0);
   endtask

   vec_t vecs[16];

   initial begin
      vec_t rv;
      int   spurious;
      vecs[0]  = '{16'h3C00, 16'h3E00, 1'b0, 16'h3E00, 4'h0};
      vecs[1]  = '{16'h4000, 16'hC200, 1'b0, 16'hC600, 4'h0};
      vecs[2]  = '{16'h3C01, 16'h3E00, 1'b0, 16'h3E02, 4'h1};
      vecs[3]  = '{16'h3C01, 16'h3E00, 1'b1, 16'h3E01, 4'h1};
      vecs[4]  = '{16'h7BFF, 16'h4000, 1'b0, 16'h7C00, 4'h5};
      vecs[5]  = '{16'h7BFF, 16'h4000, 1'b1, 16'h7BFF, 4'h5};
      vecs[6]  = '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'h8};
      vecs[7]  = '{16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 4'h0};
      vecs[8]  = '{16'h0001, 16'h3C00, 1'b0, 16'h0000, 4'h0};
      vecs[9]  = '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'h0};
      vecs[10] = '{16'h0400, 16'h0400, 1'b0, 16'h0000, 4'h3};
      vecs[11] = '{16'h8400, 16'h0400, 1'b0, 16'h8000, 4'h3};
      vecs[12] = '{16'h0000, 16'hFC00, 1'b0, 16'h7E00, 4'h8};
      vecs[13] = '{16'h3E00, 16'h3D55, 1'b0, 16'h4000, 4'h1};
      vecs[14] = '{16'h3E00, 16'h3D55, 1'b1, 16'h3FFF, 4'h1};
      vecs[15] = '{16'h3BFF, 16'h3BFF, 1'b0, 16'h3BFE, 4'h1};

      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.rnd_mode = 1'b0;
      #1;
      check(bus.out_valid == 1'b0, "rst_out_valid", 32'(bus.out_valid), 32'd0);
      check(bus.x == 16'h0000, "rst_x", 32'(bus.x), 32'd0);
      check(bus.flags == 4'h0, "rst_flags", 32'(bus.flags), 32'd0);
      check(bus.in_ready == 1'b1, "rst_in_ready", 32'(bus.in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      run_stream(6, 1'b1);

      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.a = 16'h3C00; bus.b = 16'h3E00; bus.rnd_mode = 1'b0; bus.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      check(bus.out_valid == 1'b1, "full_before_rst", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check(bus.out_valid == 1'b0, "midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check(bus.x == 16'h0000, "midrst_x", 32'(bus.x), 32'd0);
      check(bus.flags == 4'h0, "midrst_flags", 32'(bus.flags), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      spurious = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid) spurious++;
      end
      check(spurious == 0, "no_stale_after_rst", 32'(spurious), 32'd0);
      rv = '{16'h4000, 16'hC200, 1'b0, 16'hC600, 4'h0};
      apply_vec(rv, "post_rst");

      run_stream(10000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
